qpp_addr_gen: RTL and testbench

Parametrised successor to the interleaver's fixed two-size sequential counter. It generates, per block, the sequential index i together with the quadratic-permutation-polynomial interleaved address π(i) = (f1·i + f2·i²) mod K, one pair per cycle. Block size K and coefficients f1/f2 are run-time inputs latched at start. It sits between the interleaver control and the block RAM address ports, with a valid/ready handshake so the RAM side can stall it.

---
 rtl/qpp_addr_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_qpp_addr_gen.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpp_addr_gen.sv
// ---------------------------------------------------------------------------
// qpp_addr_gen
//
// Per-block address generator for a QPP turbo-code interleaver. For every
// index i of a block it emits the pair
//     seq_addr = i
//     int_addr = pi(i) = (f1*i + f2*i*i) mod K
// at one pair per cycle, with a valid/ready handshake toward the RAM side.
// K, f1 and f2 are captured when a block is started.
//
// pi(i) is built incrementally so that no multiplier is needed:
//     pi(i+1) = pi(i) + g(i)              (mod K)
//     g(i+1)  = g(i)  + step              (mod K)
//     g(0)    = f1 + f2,  step = 2*f2     (mod K)
// Every operand is kept below K, so each modular add reduces to one
// ADDR_W+1-bit add followed by at most one subtraction of K.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       begin a block (only honoured in IDLE)
//   abort       synchronous cancel of the block in progress
//   k_in        block size K         (captured on accepted start)
//   f1_in       QPP coefficient f1   (captured on accepted start)
//   f2_in       QPP coefficient f2   (captured on accepted start)
//   addr_ready  consumer accepts the current address pair
//   addr_valid  seq_addr / int_addr carry a valid pair
//   seq_addr    sequential index i
//   int_addr    interleaved address pi(i)
//   last        qualifies the pair with i = K-1
//   busy        a block is being set up, run or finished
//   done        one-cycle pulse after the final pair was accepted
//   cfg_err     one-cycle pulse when the captured configuration is illegal
// ---------------------------------------------------------------------------
module qpp_addr_gen #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] k_in,
    input  logic [ADDR_W-1:0] f1_in,
    input  logic [ADDR_W-1:0] f2_in,
    input  logic              addr_ready,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] seq_addr,
    output logic [ADDR_W-1:0] int_addr,
    output logic              last,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] K_MIN = ADDR_W'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Captured configuration
    logic [ADDR_W-1:0] k_r;
    logic [ADDR_W-1:0] f1_r;
    logic [ADDR_W-1:0] f2_r;

    // Incremental QPP datapath
    logic [ADDR_W-1:0] i_r;
    logic [ADDR_W-1:0] pi_r;
    logic [ADDR_W-1:0] g_r;
    logic [ADDR_W-1:0] step_r;

    logic cfg_err_r;

    logic cfg_illegal;
    logic at_last;
    logic start_ok;

    // (a + b) mod k for a, b < k: one wide add, at most one subtract.
    function automatic logic [ADDR_W-1:0] mod_add(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] b,
        input logic [ADDR_W-1:0] k
    );
        logic [ADDR_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, k}) begin
            sum = sum - {1'b0, k};
        end
        return sum[ADDR_W-1:0];
    endfunction

    // Configuration check runs on the captured values during SETUP.
    assign cfg_illegal = (k_r < K_MIN) || (f1_r >= k_r) || (f2_r >= k_r);
    assign at_last     = (i_r == (k_r - ONE));
    // abort seen in IDLE also suppresses a simultaneous start.
    assign start_ok    = start && !abort;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (abort || cfg_illegal) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // abort wins over a transfer in the same cycle
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (addr_ready && at_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Configuration capture and address datapath
    // -----------------------------------------------------------------------
    // NOTE: these are a handful of individual registers, not a memory array,
    // so all of them take the asynchronous reset and come up as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_r       <= '0;
            f1_r      <= '0;
            f2_r      <= '0;
            i_r       <= '0;
            pi_r      <= '0;
            g_r       <= '0;
            step_r    <= '0;
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        k_r  <= k_in;
                        f1_r <= f1_in;
                        f2_r <= f2_in;
                    end
                end
                S_SETUP: begin
                    if (!abort) begin
                        if (cfg_illegal) begin
                            cfg_err_r <= 1'b1;
                        end else begin
                            // f1, f2 < K is guaranteed here, so both sums
                            // need at most one correction.
                            g_r    <= mod_add(f1_r, f2_r, k_r);
                            step_r <= mod_add(f2_r, f2_r, k_r);
                            i_r    <= '0;
                            pi_r   <= '0;
                        end
                    end
                end
                S_RUN: begin
                    // On the final pair the counters stay at K-1 (no wrap).
                    if (!abort && addr_ready && !at_last) begin
                        i_r  <= i_r + ONE;
                        pi_r <= mod_add(pi_r, g_r, k_r);
                        g_r  <= mod_add(g_r, step_r, k_r);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded only from registered state, so addr_ready never has a
    // combinational path to addr_valid.
    // -----------------------------------------------------------------------
    assign addr_valid = (state == S_RUN);
    assign seq_addr   = i_r;
    assign int_addr   = pi_r;
    assign last       = (state == S_RUN) && at_last;
    // The error pulse cycle still counts as busy; busy drops one cycle later.
    assign busy       = (state != S_IDLE) || cfg_err_r;
    assign done       = (state == S_DONE);
    assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_qpp_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_qpp_addr_gen
//
// Directed bench for qpp_addr_gen. Inputs are driven and outputs sampled on
// the falling clock edge. Expected addresses come from hand-computed LTE
// vectors and from the closed-form QPP polynomial evaluated in the bench.
// ---------------------------------------------------------------------------
module tb_qpp_addr_gen;

    localparam int W = 13;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [W-1:0] k_in;
    logic [W-1:0] f1_in;
    logic [W-1:0] f2_in;
    logic         addr_ready;
    logic         addr_valid;
    logic [W-1:0] seq_addr;
    logic [W-1:0] int_addr;
    logic         last;
    logic         busy;
    logic         done;
    logic         cfg_err;

    qpp_addr_gen #(.ADDR_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .k_in       (k_in),
        .f1_in      (f1_in),
        .f2_in      (f2_in),
        .addr_ready (addr_ready),
        .addr_valid (addr_valid),
        .seq_addr   (seq_addr),
        .int_addr   (int_addr),
        .last       (last),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    // Per-block capture
    int got_int [8192];
    int ref_seq [1056];
    bit seen    [8192];
    int got_n;
    int done_cnt;
    int done_cyc;
    int first_valid_cyc;
    int seq_err;
    int last_err;
    int stall_err;
    bit finished;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int qpp(input int k, input int f1, input int f2, input int i);
        longint li;
        li = i;
        return int'((longint'(f1) * li + longint'(f2) * li * li) % longint'(k));
    endfunction

    function automatic logic [31:0] all_outs();
        return {1'b0, addr_valid, seq_addr, int_addr, last, busy, done, cfg_err};
    endfunction

    // Called on a falling edge; returns on the falling edge after start was
    // sampled (the first busy cycle).
    task automatic do_start(input logic [W-1:0] k, input logic [W-1:0] f1, input logic [W-1:0] f2);
        start = 1'b1;
        abort = 1'b0;
        k_in  = k;
        f1_in = f1;
        f2_in = f2;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_block(input logic [W-1:0] k, input logic [W-1:0] f1, input logic [W-1:0] f2,
                             input bit rnd, input int abort_at);
        int budget;
        bit prev_hold;
        bit seen_done;
        logic [W-1:0] h_seq;
        logic [W-1:0] h_int;
        logic         h_last;
        got_n = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
        seq_err = 0; last_err = 0; stall_err = 0; finished = 1'b0;
        prev_hold = 1'b0; h_seq = '0; h_int = '0; h_last = 1'b0;
        addr_ready = 1'b1;
        do_start(k, f1, f2);
        check("setup_busy", {31'd0, busy}, 32'd1);
        check("setup_valid", {31'd0, addr_valid}, 32'd0);
        budget = 4 * int'(k) + 50;
        while (!finished && budget > 0) begin
            @(negedge clk);
            budget--;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_hold) begin
                if (addr_valid !== 1'b1 || seq_addr !== h_seq || int_addr !== h_int || last !== h_last)
                    stall_err++;
            end
            if (addr_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (int'(seq_addr) != got_n) seq_err++;
                if (last !== (int'(seq_addr) == int'(k) - 1)) last_err++;
                if (abort_at >= 0 && int'(seq_addr) == abort_at) begin
                    abort = 1'b1;
                    addr_ready = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    check("abort_busy", {31'd0, busy}, 32'd0);
                    check("abort_valid", {31'd0, addr_valid}, 32'd0);
                    check("abort_done", {31'd0, done}, 32'd0);
                    seen_done = 1'b0;
                    repeat (4) begin
                        @(negedge clk);
                        if (done || cfg_err) seen_done = 1'b1;
                    end
                    check("abort_no_done", {31'd0, seen_done}, 32'd0);
                    finished = 1'b1;
                end else begin
                    addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    prev_hold  = !addr_ready;
                    h_seq  = seq_addr;
                    h_int  = int_addr;
                    h_last = last;
                    if (addr_ready) begin
                        got_int[got_n] = int'(int_addr);
                        got_n++;
                    end
                end
            end else begin
                prev_hold = 1'b0;
                if (done_cnt > 0 && !busy) finished = 1'b1;
            end
        end
        addr_ready = 1'b1;
        check("block_timeout", {31'd0, finished}, 32'd1);
        if (abort_at < 0) check("busy_drop", cyc - done_cyc, 32'd1);
    endtask

    task automatic verify_seq(input string tag, input int k, input int f1, input int f2);
        int merr;
        int dup;
        merr = 0;
        dup  = 0;
        for (int j = 0; j < 8192; j++) seen[j] = 1'b0;
        for (int j = 0; j < got_n; j++) begin
            if (got_int[j] != qpp(k, f1, f2, j)) merr++;
            if (got_int[j] >= k || got_int[j] < 0) dup++;
            else if (seen[got_int[j]]) dup++;
            else seen[got_int[j]] = 1'b1;
        end
        check({tag, "_len"}, got_n, k);
        check({tag, "_model"}, merr, 0);
        check({tag, "_perm"}, dup, 0);
        check({tag, "_seq"}, seq_err, 0);
        check({tag, "_last"}, last_err, 0);
        check({tag, "_done_once"}, done_cnt, 1);
    endtask

    task automatic illegal_cfg(input string tag, input logic [W-1:0] k, input logic [W-1:0] f1,
                               input logic [W-1:0] f2);
        bit saw_valid;
        saw_valid = 1'b0;
        do_start(k, f1, f2);
        check({tag, "_busy_n1"}, {31'd0, busy}, 32'd1);
        check({tag, "_err_n1"}, {31'd0, cfg_err}, 32'd0);
        @(negedge clk);
        if (addr_valid) saw_valid = 1'b1;
        check({tag, "_err_n2"}, {31'd0, cfg_err}, 32'd1);
        check({tag, "_busy_n2"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        if (addr_valid) saw_valid = 1'b1;
        check({tag, "_err_n3"}, {31'd0, cfg_err}, 32'd0);
        check({tag, "_busy_n3"}, {31'd0, busy}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            if (addr_valid) saw_valid = 1'b1;
        end
        check({tag, "_no_valid"}, {31'd0, saw_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_seq;
        int inc_err;
        int diff;
        int budget;

        reset = 1'b0; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
        k_in = '0; f1_in = '0; f2_in = '0;
        repeat (3) @(negedge clk);
        check("rst_outs_low", all_outs(), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_outs_idle", all_outs(), 32'd0);

        // LTE K=1056, no stall
        run_block(13'd1056, 13'd17, 13'd66, 1'b0, -1);
        check("k1056_i0", got_int[0], 0);
        check("k1056_i1", got_int[1], 83);
        check("k1056_i2", got_int[2], 298);
        check("k1056_i3", got_int[3], 645);
        check("k1056_i1055", got_int[1055], 49);
        check("k1056_done_lat", done_cyc - first_valid_cyc, 1056);
        verify_seq("k1056", 1056, 17, 66);
        for (int j = 0; j < 1056; j++) ref_seq[j] = got_int[j];

        // LTE K=6144
        run_block(13'd6144, 13'd263, 13'd480, 1'b0, -1);
        check("k6144_i1", got_int[1], 743);
        check("k6144_i2", got_int[2], 2446);
        check("k6144_final", got_int[6143], 217);
        verify_seq("k6144", 6144, 263, 480);

        // K=1056 with random stalls
        run_block(13'd1056, 13'd17, 13'd66, 1'b1, -1);
        diff = 0;
        for (int j = 0; j < 1056; j++) if (got_int[j] != ref_seq[j]) diff++;
        check("stall_same_seq", diff, 0);
        check("stall_hold", stall_err, 0);
        verify_seq("stall", 1056, 17, 66);

        // Illegal configurations
        illegal_cfg("ill_k1", 13'd1, 13'd0, 13'd0);
        illegal_cfg("ill_f1", 13'd40, 13'd40, 13'd10);
        illegal_cfg("ill_f2", 13'd40, 13'd3, 13'd41);

        // Abort at i=500, then a short block
        run_block(13'd1056, 13'd17, 13'd66, 1'b0, 500);
        run_block(13'd40, 13'd3, 13'd10, 1'b0, -1);
        check("k40_i1", got_int[1], 13);
        check("k40_i2", got_int[2], 6);
        check("k40_final", got_int[39], 7);
        verify_seq("k40", 40, 3, 10);

        // start held high during RUN is ignored; then async reset mid-RUN
        addr_ready = 1'b1;
        do_start(13'd1056, 13'd17, 13'd66);
        start = 1'b1;
        prev_seq = -1; inc_err = 0; budget = 300;
        while (budget > 0 && prev_seq != 100) begin
            @(negedge clk);
            budget--;
            if (addr_valid) begin
                if (prev_seq >= 0 && int'(seq_addr) != prev_seq + 1) inc_err++;
                prev_seq = int'(seq_addr);
            end else if (prev_seq >= 0) begin
                inc_err++;
            end
        end
        check("start_ignored_reach", prev_seq, 100);
        check("start_ignored_inc", inc_err, 0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_outs", all_outs(), 32'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", all_outs(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
